// File: rtl/problem_sequencer.sv
// Feeds a list of Othello positions to the processer solver one at a time and
// collects each signed result byte, with a per-problem cycle timeout.
module problem_sequencer #(
  parameter int          NUM_PROBLEMS = 4,
  parameter logic [23:0] TIMEOUT      = 24'hFFFFFF,
  parameter int          IDXW         = (NUM_PROBLEMS > 1) ? $clog2(NUM_PROBLEMS) : 1
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET,
  input  logic                      iStart,
  input  logic [128*NUM_PROBLEMS-1:0] iProblems,
  output logic [63:0]               oPlayer,
  output logic [63:0]               oOpponent,
  output logic                      oEnable,
  input  logic                      iSolved,
  input  logic [7:0]                iRes,
  output logic [8*NUM_PROBLEMS-1:0] oResult,
  output logic [IDXW-1:0]           oIndex,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oTimeout,
  output logic [4:0]                oLed
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STORE, S_DONE} state_t;

  localparam logic [23:0]     LAST_CNT = TIMEOUT - 24'd1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PROBLEMS - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [23:0]               r_count;
  logic [IDXW-1:0]           r_index;
  logic [7:0]                r_capture;
  logic                      r_timeout;
  logic [63:0]               r_player;
  logic [63:0]               r_opponent;
  logic [8*NUM_PROBLEMS-1:0] r_result;
  logic [127:0]              w_slice;
  logic                      w_accept;
  logic                      w_expire;
  logic                      w_last;
  logic [1:0]                w_idx2;

  // Counter 0 is the first RUN cycle; a leftover solved flag there is ignored.
  assign w_accept = (r_count != 24'd0) && iSolved;
  assign w_expire = (r_count == LAST_CNT);
  assign w_last   = (r_index == LAST_IDX);

  always_comb begin
    w_slice = iProblems[127:0];
    for (int k = 0; k < NUM_PROBLEMS; k++) begin
      if (r_index == IDXW'(k)) w_slice = iProblems[128*k +: 128];
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (iStart) w_next = S_LOAD;
      S_LOAD:         w_next = S_RUN;
      S_RUN:          if (w_accept || w_expire) w_next = S_STORE;
      S_STORE:        w_next = w_last ? S_DONE : S_LOAD;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_count    <= 24'd0;
      r_index    <= '0;
      r_capture  <= 8'd0;
      r_timeout  <= 1'b0;
      r_player   <= 64'd0;
      r_opponent <= 64'd0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            r_index   <= '0;
            r_timeout <= 1'b0;
            r_result  <= '0;
          end
        end
        S_LOAD: begin
          r_player   <= w_slice[127:64];
          r_opponent <= w_slice[63:0];
          r_count    <= 24'd0;
        end
        S_RUN: begin
          r_count <= r_count + 24'd1;
          // A completion on the final allowed cycle beats the timeout.
          if (w_accept) begin
            r_capture <= iRes;
          end else if (w_expire) begin
            r_capture <= 8'h80;
            r_timeout <= 1'b1;
          end
        end
        S_STORE: begin
          for (int k = 0; k < NUM_PROBLEMS; k++) begin
            if (r_index == IDXW'(k)) r_result[8*k +: 8] <= r_capture;
          end
          if (!w_last) r_index <= r_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (IDXW >= 2) begin : g_idx_wide
      assign w_idx2 = r_index[1:0];
    end else begin : g_idx_narrow
      assign w_idx2 = {1'b0, r_index[0]};
    end
  endgenerate

  assign oPlayer   = r_player;
  assign oOpponent = r_opponent;
  assign oEnable   = (r_state == S_RUN);
  assign oResult   = r_result;
  assign oIndex    = r_index;
  assign oBusy     = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_STORE);
  assign oDone     = (r_state == S_DONE);
  assign oTimeout  = r_timeout;
  assign oLed      = {oBusy, oDone, r_timeout, w_idx2};

endmodule

// File: doc/problem_sequencer.md
# problem_sequencer

Feeds a list of Othello positions to the `processer` solver one at a time and collects each signed result. It sits directly upstream of the solver: it drives the solver's board inputs and `enable`, and consumes its `solved` and `res` outputs. Between problems it holds `enable` low so the solver restarts cleanly. The result array and a status summary go to the LED driver and the top level.

## Interface
- `NUM_PROBLEMS`, default 4: number of positions in the list. Legal range 1..16.
- `TIMEOUT`, default 24'hFFFFFF: the maximum number of RUN cycles allowed per problem. It is a 24-bit value and must be at least 2.
- `IDXW`, default `$clog2(NUM_PROBLEMS)`, minimum 1: width of the index.

Ports:
- `iCLOCK` input, 1 bit: the single clock; all logic is on its rising edge.
- `iRESET` input, 1 bit: reset is synchronous and active-high.
- `iStart` input, 1 bit: single-cycle start request.
- `iProblems` input, 128*NUM_PROBLEMS bits: problem k occupies bits [128k+127:128k]. The upper 64 bits are the player board; the lower 64 bits are the opponent board.
- `oPlayer` output, 64 bits: player board presented to the solver.
- `oOpponent` output, 64 bits: opponent board presented to the solver.
- `oEnable` output, 1 bit: solver enable. While low, the solver is held in reset.
- `iSolved` input, 1 bit: solver completion flag.
- `iRes` input, 8 bits signed: solver result. It is valid while `iSolved` is high.
- `oResult` output, 8*NUM_PROBLEMS bits: stored result for problem k at bits [8k+7:8k].
- `oIndex` output, IDXW bits: index of the current problem.
- `oBusy` output, 1 bit: high in LOAD, RUN and STORE.
- `oDone` output, 1 bit: high in DONE.
- `oTimeout` output, 1 bit: sticky flag; set if any problem in the run timed out.
- `oLed` output, 5 bits: status summary, {oBusy, oDone, oTimeout, oIndex[1:0]}. If IDXW = 1, oIndex is zero-extended to 2 bits.

## Operation
- States: IDLE, LOAD, RUN, STORE, DONE.
- **IDLE**
  - `oEnable` = 0.
  - On `iStart` = 1, go to LOAD. In the same transition, clear index, the timeout flag and every `oResult` byte to 0.
- **LOAD** (exactly 1 cycle)
  - Register problem[index] onto `oPlayer`/`oOpponent`.
  - `oEnable` = 0.
  - Clear the cycle counter to 0, then go to RUN.
- **RUN**
  - `oEnable` = 1.
  - The cycle counter increments every cycle.
  - `iSolved` is ignored in the first RUN cycle (counter = 0). This is a guard against a stale flag.
  - From counter ≥ 1: if `iSolved` = 1, capture `iRes` and go to STORE.
  - Else, if counter = TIMEOUT−1, capture 8'h80 (−128), set `oTimeout`, and go to STORE.
  - If `iSolved` rises on the timeout cycle, `iSolved` wins and `oTimeout` is not set.
- **STORE** (exactly 1 cycle)
  - `oEnable` = 0.
  - Write the captured byte to `oResult[index]`.
  - If index = NUM_PROBLEMS−1, go to DONE. Otherwise increment index and go to LOAD.
- **DONE**
  - `oEnable` = 0. Results and `oTimeout` are held.
  - On `iStart`, restart exactly as from IDLE.
- `iStart` is ignored in LOAD, RUN and STORE.
- Board outputs hold their last value outside LOAD.
- Arithmetic:
  - The counter is 24 bits unsigned.
  - Index increments only in STORE and never wraps within a run.
  - `iRes` is stored bit-exact. No sign extension is needed.

## Timing
- Reset values: state = IDLE; `oPlayer` = `oOpponent` = 0; `oEnable` = 0; `oResult` = 0; `oIndex` = 0; `oBusy` = `oDone` = `oTimeout` = 0; `oLed` = 0.
- `iRESET` asserted in any state, including mid-RUN, forces all of the above on the next edge. Partial results are discarded.
- All outputs are registered. No combinational input-to-output path exists.
- Latency from `iStart` to `oEnable` high: LOAD is entered one edge after `iStart`, and `oEnable` rises one edge after that (2 edges total).
- Per problem:
  - 1 LOAD cycle + R RUN cycles + 1 STORE cycle, where R = (cycle of accepted `iSolved`) + 1.
  - Minimum R = 2; maximum R = TIMEOUT.
- `oEnable` is low for at least 2 consecutive cycles (STORE, then LOAD) between problems.
- `oResult[k]` is updated on the edge that leaves STORE for problem k.
- `oDone` rises on the edge after the last STORE.

## Test plan
- **Single problem:** NUM_PROBLEMS=1. Problem = {64'h0018247A32464800, 64'h3E255B854D39357E}. Pulse `iStart`; assert `iSolved` with `iRes`=8'sd6 on the 10th RUN cycle. Required: `oResult`=8'h06, `oDone`=1, `oTimeout`=0, `oLed`=5'b01000.
- **Four problems:** four problems with results +3, −2, 0, +64. Required:
  - `oResult` = {8'h40, 8'h00, 8'hFE, 8'h03}.
  - Each LOAD presents the correct 128-bit slice.
  - `oEnable` is low for exactly 2 cycles between problems.
- **Timeout:** TIMEOUT=16, and the solver never completes. Required:
  - `oEnable` is high for exactly 16 cycles.
  - The stored byte is 8'h80 and `oTimeout`=1.
  - The sequencer then proceeds to the next problem.
- **Guard and tie:**
  - `iSolved` held high from the first RUN cycle: it is ignored in cycle 0 and accepted in cycle 1.
  - With TIMEOUT=16, `iSolved` at counter 15: the result is stored and `oTimeout` stays 0.
- **Busy start:** `iStart` pulsed mid-RUN has no effect. `iStart` in DONE clears the results and restarts at index 0.
- **Reset mid-operation:** `iRESET` asserted during RUN of problem 2. On the next edge all outputs return to reset values, and `oEnable` is 0.
